// File: rtl/game_level_sequencer.sv
// Game-flow controller: title, level launch, countdown, scoring, pass/fail/win.
// Define LEVEL_SEQ_PAUSE_EN to add a pause_key input and a PAUSED state (6).
module game_level_sequencer #(
  parameter int NUM_LEVELS     = 4,
  parameter int LEVEL_TIME_SEC = 60,
  parameter int FRAMES_PER_SEC = 30,
  parameter int GOAL_BASE      = 50,
  parameter int GOAL_STEP      = 40
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        is_enter_pressed,
  input  logic        level_ended,
  input  logic        score_pulse,
  input  logic [7:0]  score_value,
`ifdef LEVEL_SEQ_PAUSE_EN
  input  logic        pause_key,
`endif
  output logic        start_level,
  output logic        timer_endedN,
  output logic [15:0] goal,
  output logic [2:0]  level_num,
  output logic [6:0]  seconds_left,
  output logic [15:0] level_score,
  output logic [15:0] total_score,
  output logic [2:0]  game_state
);

`ifdef LEVEL_SEQ_PAUSE_EN
  typedef enum logic [2:0] {
    S_TITLE, S_LAUNCH, S_PLAYING, S_LEVEL_DONE,
    S_GAME_OVER, S_GAME_WON, S_PAUSED
  } state_t;
`else
  typedef enum logic [2:0] {
    S_TITLE, S_LAUNCH, S_PLAYING, S_LEVEL_DONE,
    S_GAME_OVER, S_GAME_WON
  } state_t;
`endif

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]  SEC_INIT = 7'(LEVEL_TIME_SEC);
  localparam logic [2:0]  LAST_LVL = 3'(NUM_LEVELS - 1);
  localparam logic [15:0] GOAL_B   = 16'(GOAL_BASE);
  localparam logic [15:0] GOAL_S   = 16'(GOAL_STEP);

  state_t        state;
  logic          enter_q;
  logic          eval_pending;
  logic [FW-1:0] frame_cnt;
  logic          enter_edge;
  logic          score_en;

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [7:0]  b
  );
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign enter_edge = is_enter_pressed & ~enter_q;
  assign game_state = state;

`ifdef LEVEL_SEQ_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = pause_key & ~pause_q;
  assign score_en = score_pulse & ((state == S_PLAYING) |
                    (state == S_LEVEL_DONE) | (state == S_PAUSED));
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) pause_q <= 1'b0;
    else         pause_q <= pause_key;
`else
  assign score_en = score_pulse & ((state == S_PLAYING) |
                    (state == S_LEVEL_DONE));
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_TITLE;
      enter_q      <= 1'b0;
      eval_pending <= 1'b0;
      frame_cnt    <= '0;
      start_level  <= 1'b0;
      timer_endedN <= 1'b1;
      goal         <= GOAL_B;
      level_num    <= '0;
      seconds_left <= SEC_INIT;
      level_score  <= '0;
      total_score  <= '0;
    end else begin
      enter_q     <= is_enter_pressed;
      start_level <= 1'b0;
      goal        <= GOAL_B + GOAL_S * {13'd0, level_num};
      if (score_en) begin
        level_score <= sat_add(level_score, score_value);
        total_score <= sat_add(total_score, score_value);
      end
      unique case (state)
        S_TITLE: if (enter_edge) begin
          level_num    <= '0;
          level_score  <= '0;
          total_score  <= '0;
          seconds_left <= SEC_INIT;
          frame_cnt    <= '0;
          timer_endedN <= 1'b1;
          start_level  <= 1'b1;
          state        <= S_LAUNCH;
        end
        S_LAUNCH: state <= S_PLAYING;
        S_PLAYING: begin
          if (startOfFrame) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (seconds_left != 7'd0)
                seconds_left <= seconds_left - 7'd1;
              if (seconds_left == 7'd1)
                timer_endedN <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
          if (level_ended && !timer_endedN) begin
            eval_pending <= 1'b1;
            state        <= S_LEVEL_DONE;
          end
`ifdef LEVEL_SEQ_PAUSE_EN
          else if (pause_edge) state <= S_PAUSED;
`endif
        end
        // Decide one cycle late so a pulse on the entry cycle is included
        S_LEVEL_DONE: begin
          if (eval_pending) begin
            eval_pending <= 1'b0;
          end else if (level_score < goal) begin
            state <= S_GAME_OVER;
          end else if (level_num == LAST_LVL) begin
            state <= S_GAME_WON;
          end else if (enter_edge) begin
            level_num    <= level_num + 3'd1;
            level_score  <= '0;
            seconds_left <= SEC_INIT;
            timer_endedN <= 1'b1;
            frame_cnt    <= '0;
            start_level  <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_GAME_OVER, S_GAME_WON:
          if (enter_edge) state <= S_TITLE;
`ifdef LEVEL_SEQ_PAUSE_EN
        S_PAUSED: if (pause_edge) state <= S_PLAYING;
`endif
        default: state <= S_TITLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_level_sequencer.sv
// Directed bench for game_level_sequencer: launch, timer, scoring,
// pass/win/fail flow, saturation and async reset.
module tb_game_level_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        is_enter_pressed;
  logic        level_ended;
  logic        score_pulse;
  logic [7:0]  score_value;
  logic        start_level;
  logic        timer_endedN;
  logic [15:0] goal;
  logic [2:0]  level_num;
  logic [6:0]  seconds_left;
  logic [15:0] level_score;
  logic [15:0] total_score;
  logic [2:0]  game_state;
`ifdef LEVEL_SEQ_PAUSE_EN
  logic        pause_key;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int launches;
  int starts;

  always #5 clk = ~clk;

  game_level_sequencer #(
    .NUM_LEVELS(2),
    .LEVEL_TIME_SEC(3),
    .FRAMES_PER_SEC(2),
    .GOAL_BASE(50),
    .GOAL_STEP(40)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .is_enter_pressed(is_enter_pressed),
    .level_ended(level_ended),
    .score_pulse(score_pulse),
    .score_value(score_value),
`ifdef LEVEL_SEQ_PAUSE_EN
    .pause_key(pause_key),
`endif
    .start_level(start_level),
    .timer_endedN(timer_endedN),
    .goal(goal),
    .level_num(level_num),
    .seconds_left(seconds_left),
    .level_score(level_score),
    .total_score(total_score),
    .game_state(game_state)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic score(input logic [7:0] v);
    score_pulse = 1'b1;
    score_value = v;
    tick();
    score_pulse = 1'b0;
    tick();
  endtask

  task automatic press_enter();
    is_enter_pressed = 1'b1;
    tick();
    is_enter_pressed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    is_enter_pressed = 1'b0;
    level_ended = 1'b0;
    score_pulse = 1'b0;
    score_value = 8'd0;
`ifdef LEVEL_SEQ_PAUSE_EN
    pause_key = 1'b0;
`endif
    repeat (3) tick();
    check("rst_state", game_state, 0);
    check("rst_start", start_level, 0);
    check("rst_timer", timer_endedN, 1);
    check("rst_goal", goal, 50);
    check("rst_sec", seconds_left, 3);
    check("rst_lvl", level_num, 0);
    check("rst_lscore", level_score, 0);
    check("rst_tscore", total_score, 0);
    resetN = 1'b1;
    tick();

    // Held Enter launches exactly once
    launches = 0;
    starts = 0;
    is_enter_pressed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (game_state == 3'd1) launches++;
      if (start_level) starts++;
    end
    is_enter_pressed = 1'b0;
    tick();
    check("hold_launches", launches, 1);
    check("hold_starts", starts, 1);
    check("play_state", game_state, 2);
    check("play_goal0", goal, 50);

    // level_ended while the timer runs is ignored
    level_ended = 1'b1;
    frames(2);
    check("sec_after2", seconds_left, 2);
    check("early_end_ign", game_state, 2);
    check("timer_run", timer_endedN, 1);
    score(8'd30);
    check("lscore30", level_score, 30);
    frames(3);
    check("sec_after5", seconds_left, 1);
    startOfFrame = 1'b1;
    score_pulse = 1'b1;
    score_value = 8'd25;
    tick();
    startOfFrame = 1'b0;
    score_pulse = 1'b0;
    check("sec_zero", seconds_left, 0);
    check("timer_end", timer_endedN, 0);
    check("lscore55", level_score, 55);
    check("tscore55", total_score, 55);
    tick();
    check("done_state", game_state, 3);
    repeat (3) tick();
    check("done_wait", game_state, 3);
    level_ended = 1'b0;
    press_enter();
    check("l1_launch", game_state, 1);
    check("l1_start", start_level, 1);
    check("l1_num", level_num, 1);
    check("l1_lscore", level_score, 0);
    check("l1_tscore", total_score, 55);
    tick();
    check("l1_start_off", start_level, 0);
    check("l1_goal", goal, 90);
    check("l1_sec", seconds_left, 3);
    check("l1_timer", timer_endedN, 1);

    // Saturation: 55 + 256*255 + 185 = 0xFFF0
    score_pulse = 1'b1;
    score_value = 8'd255;
    repeat (256) tick();
    score_value = 8'd185;
    tick();
    score_pulse = 1'b0;
    check("tscore_fff0", total_score, 16'hFFF0);
    check("lscore_ffb9", level_score, 16'hFFB9);
    score(8'd255);
    check("tscore_sat", total_score, 16'hFFFF);
    check("lscore_sat", level_score, 16'hFFFF);
    level_ended = 1'b1;
    frames(6);
    check("l1_timer_end", timer_endedN, 0);
    repeat (3) tick();
    check("won_state", game_state, 5);
    level_ended = 1'b0;
    score(8'd10);
    check("won_frozen", total_score, 16'hFFFF);
    press_enter();
    tick();
    check("won_to_title", game_state, 0);
    check("title_keep_t", total_score, 16'hFFFF);
    check("title_keep_l", level_num, 1);
    press_enter();
    check("relaunch", game_state, 1);
    check("relaunch_tot", total_score, 0);
    check("relaunch_lvl", level_num, 0);
    tick();
    check("relaunch_goal", goal, 50);

    // Failing level 0
    score(8'd20);
    level_ended = 1'b1;
    frames(6);
    repeat (3) tick();
    check("over_state", game_state, 4);
    score(8'd9);
    check("over_lscore", level_score, 20);
    check("over_tscore", total_score, 20);
    level_ended = 1'b0;
    press_enter();
    tick();
    check("over_to_title", game_state, 0);
    check("title_tscore", total_score, 20);

    // Async reset mid-level
    press_enter();
    tick();
    frames(2);
    score(8'd7);
    check("pre_rst_sec", seconds_left, 2);
`ifdef LEVEL_SEQ_PAUSE_EN
    pause_key = 1'b1;
    tick();
    pause_key = 1'b0;
    check("paused", game_state, 6);
    frames(10);
    score(8'd3);
    check("pause_sec", seconds_left, 2);
    check("pause_score", level_score, 10);
    pause_key = 1'b1;
    tick();
    pause_key = 1'b0;
    check("unpaused", game_state, 2);
`endif
    #3 resetN = 1'b0;
    #1;
    check("arst_state", game_state, 0);
    check("arst_sec", seconds_left, 3);
    check("arst_timer", timer_endedN, 1);
    check("arst_lscore", level_score, 0);
    check("arst_tscore", total_score, 0);
    check("arst_goal", goal, 50);
    repeat (2) tick();
    check("arst_start", start_level, 0);
    resetN = 1'b1;
    tick();
    check("post_rst_state", game_state, 0);
    check("post_rst_start", start_level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
